out_channel_checker: RTL and testbench
======================================

// Module: out_channel_checker
// PURPOSE
//  Consumer end of the fpga out channel: accepts words emitted by a program's `out` instructions over a valid/ready
//  handshake. Compares each word, in order, against a loaded expected table and raises finished/success.
//  Sits beside the fpga program engine on the test board; replaces the hard-coded end-of-program outMem compare.
// PARAMETERS
//  MemoryElementWidth  12      width of one channel word / expected entry
//  NOut                1       number of words the program is expected to emit (1..256)
//  TimeoutCycles       1024    cycles without a new word in COLLECT before declaring failure (>=1)
// PORTS
//  clock           in   1                    single clock, rising edge
//  reset_n         in   1                    asynchronous, active-low reset
//  run             in   1                    pulse: clear results, enter COLLECT
//  exp_we          in   1                    expected-table write strobe (honoured only in IDLE/DONE)
//  exp_addr        in   $clog2(NOut)+1       expected-table index
//  exp_data        in   MemoryElementWidth   expected word
//  out_valid       in   1                    producer has a word
//  out_data        in   MemoryElementWidth   word from program out instruction
//  out_ready       out  1                    checker accepts word this cycle
//  program_done    in   1                    producer signals program end (ip past last instruction)
//  finished        out  1                    checking complete (sticky until run/reset)
//  success         out  1                    valid only when finished; 1 = all words matched, count exact
//  received_count  out  $clog2(NOut)+2       words accepted since run, saturating at NOut+1
//  mismatch_index  out  $clog2(NOut)+1       index of first mismatching word; all-ones if none
// BEHAVIOUR
//  Reset values: out_ready=0, finished=0, success=0, received_count=0, mismatch_index=all-ones, state=IDLE.
//  The expected table is not cleared by reset.
//  FSM: IDLE -run-> COLLECT; COLLECT -(program_done | timeout)-> CHECK; CHECK -1 cycle-> DONE; DONE -run-> COLLECT.
//  out_ready=1 only in COLLECT. A transfer occurs when out_valid&out_ready at the rising edge; one word per cycle.
//  Each transfer compares out_data to table[received_count]. On the first mismatch, latch mismatch_index.
//  Transfers after NOut words: count to NOut+1 (saturating), set the overflow flag, no compare.
//  Timeout counter: reloads on run and on every transfer, decrements in COLLECT. Reaching 0 forces CHECK with the
//  timeout flag set.
//  program_done and a transfer in the same cycle: the transfer is counted/compared first, then CHECK is entered.
//  CHECK: success = no mismatch & !overflow & !timeout & received_count==NOut. finished rises one cycle later, with
//  success valid in the same cycle.
//  run while in COLLECT/CHECK restarts: clear counters, flags and mismatch_index; stay in/enter COLLECT; a word
//  presented in that cycle is not accepted.
//  exp_we in COLLECT/CHECK is ignored. exp_addr>=NOut is ignored.
//  Asynchronous reset mid-transfer drops the word; the producer sees out_ready fall immediately.
// CONFIGURATION
//  OUT_CHECKER_CAPTURE_EN defined: every accepted word (first NOut only) is also stored in a capture RAM, read via
//   extra ports cap_addr (in) and cap_data (out, combinational read); used for board debug of failing programs.
//  Undefined: no capture RAM and no cap_* ports; checking behaviour is identical.
// STRUCTURE
//  Package fpga_pkg: typedef word_t (logic [MemoryElementWidth-1:0]) and enum checker_state_t {IDLE,COLLECT,CHECK,DONE}.
//  Also holds the all-ones NoMismatch constant and the default TimeoutCycles.
//  One sub-module: out_expected_ram. It is an NOut-entry word memory with one synchronous write port and one
//  combinational read port, instantiated for the expected table and (when capture is enabled) for the capture RAM.
// TESTING
//  NOut=1, table[0]=2; run; send 2; program_done -> finished=1, success=1, received_count=1, mismatch_index=all-ones.
//  NOut=1, table[0]=2; send 3; program_done -> finished=1, success=0, mismatch_index=0.
//  NOut=3, table={1,2,4}; send 1,2,4,8 -> received_count=4, success=0 (overflow), mismatch_index=all-ones.
//  NOut=2, TimeoutCycles=8; send one word, then idle -> finished exactly 8 cycles after the transfer + CHECK
//  cycle, success=0.
//  run mid-COLLECT after a mismatching word, then send correct words -> success=1 (results cleared).
//  Assert reset_n low during COLLECT with out_valid=1 -> out_ready=0 at once, all outputs at reset values; table kept.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared types and constants for the fpga out-channel checker.
package fpga_pkg;

  localparam int DefaultMemoryElementWidth = 12;
  localparam int DefaultTimeoutCycles      = 1024;

  // Truncated to the index width at the point of use.
  localparam logic [31:0] NoMismatch = '1;

  typedef logic [DefaultMemoryElementWidth-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } checker_state_t;

endpackage

// File: rtl/out_expected_ram.sv
// Depth-entry word memory: one synchronous write port, one combinational read port.
// Addresses at or beyond Depth are ignored on write and read back as zero.
module out_expected_ram #(
  parameter int Width     = 12,
  parameter int Depth     = 1,
  parameter int AddrWidth = 1
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we && (32'(waddr) < Depth)) begin
      mem[waddr[IdxWidth-1:0]] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < Depth) ? mem[raddr[IdxWidth-1:0]] : '0;

endmodule

// File: rtl/out_channel_checker.sv
// Consumer end of the fpga out channel: checks emitted words against an expected table.
// Define OUT_CHECKER_CAPTURE_EN to add a capture RAM readable through cap_addr/cap_data.
//
// Handshake: a word transfers on a rising edge where out_valid && out_ready; out_ready is high
// only in COLLECT and is held low in a cycle where run is asserted, so a restart never eats a word.
module out_channel_checker
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = DefaultMemoryElementWidth,
  parameter int NOut               = 1,
  parameter int TimeoutCycles      = DefaultTimeoutCycles,
  localparam int AW = $clog2(NOut) + 1,
  localparam int CW = $clog2(NOut) + 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          run,
  input  logic                          exp_we,
  input  logic [AW-1:0]                 exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  input  logic                          program_done,
  output logic                          finished,
  output logic                          success,
  output logic [CW-1:0]                 received_count,
  output logic [AW-1:0]                 mismatch_index,
`ifdef OUT_CHECKER_CAPTURE_EN
  input  logic [AW-1:0]                 cap_addr,
  output logic [MemoryElementWidth-1:0] cap_data,
`endif
  output logic [1:0]                    state_dbg
);

  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [CW-1:0] NOutC    = CW'(NOut);
  localparam logic [CW-1:0] SatC     = CW'(NOut + 1);
  localparam logic [AW-1:0] NoMm     = NoMismatch[AW-1:0];
  localparam logic [TW-1:0] TimeoutC = TW'(TimeoutCycles);

  checker_state_t                state;
  logic [CW-1:0]                 count;
  logic [AW-1:0]                 mm_idx;
  logic                          overflow;
  logic                          timed_out;
  logic [TW-1:0]                 timer;
  logic                          finished_q;
  logic                          success_q;
  logic [MemoryElementWidth-1:0] exp_word;
  logic                          table_we;
  logic                          xfer;
  logic                          in_range;
  logic                          timeout_hit;

  assign out_ready   = (state == COLLECT) && !run;
  assign xfer        = out_valid && out_ready;
  assign in_range    = (count < NOutC);
  assign table_we    = exp_we && ((state == IDLE) || (state == DONE));
  // Timer at 1 with no word this edge means it reaches 0 now.
  assign timeout_hit = (timer == TW'(1)) && !xfer;

  out_expected_ram #(
    .Width     (MemoryElementWidth),
    .Depth     (NOut),
    .AddrWidth (AW)
  ) u_expected (
    .clock (clock),
    .we    (table_we),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (count[AW-1:0]),
    .rdata (exp_word)
  );

`ifdef OUT_CHECKER_CAPTURE_EN
  out_expected_ram #(
    .Width     (MemoryElementWidth),
    .Depth     (NOut),
    .AddrWidth (AW)
  ) u_capture (
    .clock (clock),
    .we    (xfer && in_range),
    .waddr (count[AW-1:0]),
    .wdata (out_data),
    .raddr (cap_addr),
    .rdata (cap_data)
  );
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= '0;
      mm_idx     <= NoMm;
      overflow   <= 1'b0;
      timed_out  <= 1'b0;
      timer      <= TimeoutC;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
    end else if (run) begin
      state      <= COLLECT;
      count      <= '0;
      mm_idx     <= NoMm;
      overflow   <= 1'b0;
      timed_out  <= 1'b0;
      timer      <= TimeoutC;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (xfer) begin
            timer <= TimeoutC;
            if (in_range) begin
              if ((out_data != exp_word) && (mm_idx == NoMm)) begin
                mm_idx <= count[AW-1:0];
              end
              count <= count + CW'(1);
            end else begin
              overflow <= 1'b1;
              if (count != SatC) begin
                count <= count + CW'(1);
              end
            end
          end else begin
            timer <= timer - TW'(1);
          end
          // A word accepted on this edge is already counted above.
          if (program_done || timeout_hit) begin
            state <= CHECK;
          end
          if (timeout_hit) begin
            timed_out <= 1'b1;
          end
        end
        CHECK: begin
          state      <= DONE;
          finished_q <= 1'b1;
          success_q  <= (mm_idx == NoMm) && !overflow && !timed_out && (count == NOutC);
        end
        default: begin
        end
      endcase
    end
  end

  assign finished       = finished_q;
  assign success        = success_q;
  assign received_count = count;
  assign mismatch_index = mm_idx;
  assign state_dbg      = state;

endmodule

// File: tb/tb_out_channel_checker.sv
// Bench for out_channel_checker: directed cases plus randomized runs against a table-level model.
module tb_out_channel_checker;

  localparam int W  = 12;
  localparam int N  = 3;
  localparam int TO = 8;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam logic [AW-1:0] NONE = 3'b111;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [W-1:0]  exp_data = '0;
  logic          out_valid = 1'b0;
  logic [W-1:0]  out_data = '0;
  logic          out_ready;
  logic          program_done = 1'b0;
  logic          finished;
  logic          success;
  logic [CW-1:0] received_count;
  logic [AW-1:0] mismatch_index;
  logic [1:0]    state_dbg;
`ifdef OUT_CHECKER_CAPTURE_EN
  logic [AW-1:0] cap_addr = '0;
  logic [W-1:0]  cap_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sent_q[$];

  out_channel_checker #(
    .MemoryElementWidth (W),
    .NOut               (N),
    .TimeoutCycles      (TO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .run            (run),
    .exp_we         (exp_we),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .program_done   (program_done),
    .finished       (finished),
    .success        (success),
    .received_count (received_count),
    .mismatch_index (mismatch_index),
`ifdef OUT_CHECKER_CAPTURE_EN
    .cap_addr       (cap_addr),
    .cap_data       (cap_data),
`endif
    .state_dbg      (state_dbg)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge only.
  task automatic drive(input logic r, input logic v, input logic [W-1:0] d, input logic done);
    @(negedge clock);
    run          = r;
    out_valid    = v;
    out_data     = d;
    program_done = done;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, 1'b0);
    @(posedge clock);
  endtask

  task automatic write_raw(input logic [AW-1:0] a, input logic [W-1:0] d);
    drive(1'b0, 1'b0, '0, 1'b0);
    exp_we   = 1'b1;
    exp_addr = a;
    exp_data = d;
    @(posedge clock);
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  task automatic load_table(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    for (int i = 0; i < N; i++) write_raw(AW'(i), exp_q[i]);
  endtask

  task automatic run_pulse(input logic with_word, input logic [W-1:0] w);
    drive(1'b1, with_word, w, 1'b0);
    #1;
    chk("ready_low_during_run", out_ready, 0);
    @(posedge clock);
    sent_q.delete();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic done);
    int t;
    drive(1'b0, 1'b1, w, done);
    #1;
    t = 0;
    while (!out_ready && t < 20) begin
      @(negedge clock);
      #1;
      t++;
    end
    chk("ready_seen", (t < 20), 1);
    @(posedge clock);
    sent_q.push_back(w);
  endtask

  task automatic wait_finished(output int cyc);
    drive(1'b0, 1'b0, '0, 1'b0);
    cyc = 0;
    while (!finished && cyc < 60) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("finish_seen", finished, 1);
  endtask

  task automatic done_and_wait();
    int cyc;
    drive(1'b0, 1'b0, '0, 1'b1);
    @(posedge clock);
    wait_finished(cyc);
    chk("check_latency", cyc, 1);
  endtask

  // Reference model: result derived from the sent words and the expected table.
  task automatic check_model(input bit timed_out);
    int n;
    int exp_cnt;
    logic [AW-1:0] mm;
    bit succ;
    n = sent_q.size();
    exp_cnt = (n > N + 1) ? N + 1 : n;
    mm = NONE;
    for (int i = 0; i < n && i < N; i++) begin
      if (sent_q[i] !== exp_q[i] && mm == NONE) mm = AW'(i);
    end
    succ = !timed_out && (n == N) && (mm == NONE);
    chk("finished", finished, 1);
    chk("success", success, succ);
    chk("received_count", received_count, exp_cnt);
    chk("mismatch_index", mismatch_index, mm);
    chk("state_done", state_dbg, int'(fpga_pkg::DONE));
  endtask

  task automatic send_table(input logic done_with_last);
    for (int i = 0; i < N; i++) send_word(exp_q[i], done_with_last && (i == N - 1));
  endtask

  initial begin
    int cyc;
    int n;
    int mode;
    logic [W-1:0] w;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_out_ready", out_ready, 0);
    chk("rst_finished", finished, 0);
    chk("rst_success", success, 0);
    chk("rst_count", received_count, 0);
    chk("rst_mismatch", mismatch_index, NONE);
    chk("rst_state", state_dbg, int'(fpga_pkg::IDLE));
    reset_n = 1'b1;

    // Exact match, program_done on its own cycle
    load_table(12'd1, 12'd2, 12'd4);
    run_pulse(1'b0, '0);
    send_table(1'b0);
    done_and_wait();
    check_model(1'b0);
`ifdef OUT_CHECKER_CAPTURE_EN
    for (int i = 0; i < N; i++) begin
      cap_addr = AW'(i);
      #1;
      chk("capture", cap_data, exp_q[i]);
    end
`endif

    // Overflow: one word too many
    run_pulse(1'b0, '0);
    send_table(1'b0);
    send_word(12'd8, 1'b1);
    wait_finished(cyc);
    check_model(1'b0);
    chk("overflow_count", received_count, 4);

    // Mismatch at index 1, program_done with the last word
    run_pulse(1'b0, '0);
    send_word(12'd1, 1'b0);
    send_word(12'd3, 1'b0);
    send_word(12'd4, 1'b1);
    wait_finished(cyc);
    chk("same_cycle_done_latency", cyc, 1);
    check_model(1'b0);
    chk("mismatch_at_1", mismatch_index, 1);

    // Timeout: one word, then silence
    run_pulse(1'b0, '0);
    send_word(12'd1, 1'b0);
    wait_finished(cyc);
    chk("timeout_latency", cyc, TO + 1);
    check_model(1'b1);

    // Restart mid-COLLECT after a bad word; word offered during run is dropped
    run_pulse(1'b0, '0);
    send_word(12'd5, 1'b0);
    run_pulse(1'b1, 12'd9);
    send_table(1'b1);
    wait_finished(cyc);
    check_model(1'b0);
    chk("restart_success", success, 1);

    // Table writes during COLLECT and out-of-range addresses are ignored
    write_raw(3'd4, 12'd999);
    write_raw(3'd7, 12'd998);
    run_pulse(1'b0, '0);
    write_raw(3'd1, 12'd77);
    send_table(1'b0);
    done_and_wait();
    check_model(1'b0);
    chk("ignored_writes_success", success, 1);

    // Asynchronous reset mid-transfer
    run_pulse(1'b0, '0);
    send_word(12'd7, 1'b0);
    drive(1'b0, 1'b1, 12'd2, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_ready", out_ready, 0);
    chk("ar_count", received_count, 0);
    chk("ar_mismatch", mismatch_index, NONE);
    chk("ar_finished", finished, 0);
    chk("ar_state", state_dbg, int'(fpga_pkg::IDLE));
    drive(1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    run_pulse(1'b0, '0);
    send_table(1'b0);
    done_and_wait();
    check_model(1'b0);
    chk("table_kept_success", success, 1);

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      load_table(W'($urandom_range(0, 4095)), W'($urandom_range(0, 4095)),
                 W'($urandom_range(0, 4095)));
      run_pulse(1'b0, '0);
      n = $urandom_range(0, 5);
      mode = $urandom_range(0, 3);
      if (mode == 1 && n == 0) mode = 2;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        if (i < N && $urandom_range(0, 3) != 0) w = exp_q[i];
        else w = W'($urandom_range(0, 4095));
        send_word(w, (mode == 1) && (i == n - 1));
      end
      if (mode == 0) begin
        wait_finished(cyc);
        chk("rand_timeout_latency", cyc, TO + 1);
        check_model(1'b1);
      end else if (mode == 1) begin
        wait_finished(cyc);
        chk("rand_check_latency", cyc, 1);
        check_model(1'b0);
      end else begin
        done_and_wait();
        check_model(1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
